core_result_reporter: RTL and testbench
=======================================

// Module: core_result_reporter
// PURPOSE
//  Multi-core successor to the per-core "saved register -> peripheral" reporting path.
//  Snoops the writeback ports of NUM_CORES cores and filters writes by a register mask.
//  Buffers qualifying writes in per-core FIFOs, then drains them round-robin.
//  Output is one valid/ready to_peripheral channel tagged with core ID and register number.
// PARAMETERS
//  NUM_CORES   4             number of snooped cores (1..16)
//  CORE_BITS   2             core ID width; must satisfy 2**CORE_BITS >= NUM_CORES
//  DATA_WIDTH  32            register data width
//  FIFO_DEPTH  4             entries per core FIFO; power of 2, >= 2
//  REG_MASK    32'h03FC_0200 bit r set = report writes to xr (default x9, x18-x25)
// PORTS
//  clock                in   1                      system clock, rising edge
//  reset                in   1                      asynchronous, active-high
//  write                in   NUM_CORES              per-core writeback strobe
//  write_reg            in   NUM_CORES*5            per-core destination register; core i = [5i+4:5i]
//  write_data           in   NUM_CORES*DATA_WIDTH   per-core writeback data
//  to_peripheral_valid  out  1                      output entry valid
//  to_peripheral_ready  in   1                      peripheral accepts entry
//  to_peripheral_core   out  CORE_BITS              source core of entry
//  to_peripheral_reg    out  5                      register number of entry
//  to_peripheral_data   out  DATA_WIDTH             register value of entry
//  overflow             out  NUM_CORES              sticky: core i lost at least one entry
// BEHAVIOUR
//  Reset (async): all FIFOs empty, rr pointer = 0. All outputs 0, including valid and overflow.
//  Qualify: write[i] && REG_MASK[write_reg[i]] && write_reg[i] != 0.
//    Writes to x0 are never reported, whatever the mask says.
//  Capture: a qualifying write is pushed {reg,data} into FIFO i at the same rising edge.
//  Full FIFO:
//    - If the FIFO is also popped in this cycle, the push is accepted.
//    - Otherwise the entry is dropped and overflow[i] is set. It clears only on reset.
//  FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
//    full = MSBs differ and LSBs equal; empty = pointers equal.
//  Output stage is a single register; it loads when (!valid || (valid && ready)).
//  Arbiter: on load, select the first non-empty FIFO scanning from rr pointer upward, mod NUM_CORES.
//    Pop that FIFO; set rr = selected+1 mod NUM_CORES.
//    If no FIFO is non-empty, valid clears (or stays 0).
//  Handshake:
//    - Transfer occurs on an edge with valid && ready.
//    - While valid && !ready, core/reg/data are held stable.
//    - valid never drops without a transfer.
//  Latency: a write captured at edge k appears at the output no earlier than edge k+1.
//    No bypass from write to output.
//  Throughput: one entry per cycle with ready held high.
//  Same-cycle qualifying writes from several cores are all captured, one per FIFO.
//  Entries from one core leave in capture order; no ordering is guaranteed across cores.
//  Reset mid-transfer: pending entries are discarded and valid drops asynchronously.
// CONFIGURATION
//  REPORTER_DROP_COUNT_EN defined:
//    Adds output drop_count [NUM_CORES*16], 16 bits per core, reset 0.
//    Each count increments once per dropped entry and saturates at 16'hFFFF.
//    overflow is unchanged.
//  REPORTER_DROP_COUNT_EN undefined: the port and the counters do not exist.
// TESTING
//  Core 0 writes x9=5, ready=1 -> one beat: core=0, reg=9, data=5, valid 1 cycle after capture.
//  Core 1 writes x5 (mask bit clear) and x0 -> no output; overflow stays 0.
//  Cores 0..3 write x18 with data 10..13 in one cycle, ready=1, rr=0
//    -> 4 consecutive beats from cores 0,1,2,3.
//  ready=0; core 2 writes x20 with data 1..6 in 6 cycles (depth 4)
//    -> output holds data=1; entries 2..5 are stored (4 entries in the FIFO); data=6 is dropped.
//    -> overflow=4'b0100; drop_count[2]=1 if REPORTER_DROP_COUNT_EN.
//    -> after ready=1: beats 1..5 in order, then valid=0.
//  ready toggled randomly with valid held -> payload unchanged across every stall cycle.
//  reset asserted mid-stream -> valid, overflow and FIFOs cleared immediately.
//    -> no stale beat appears after release.

Source files
------------

// File: rtl/core_result_reporter.sv
// Purpose: snoop NUM_CORES writeback ports, buffer masked register writes per core, drain round-robin.
// Latency: a write captured at edge k reaches the output register at edge k+1 at the earliest.
// Backpressure: output holds while valid && !ready; a full core FIFO drops its new entry and sets sticky overflow.
// Optional feature: define REPORTER_DROP_COUNT_EN to add per-core saturating 16-bit drop counters.
module core_result_reporter #(
  parameter int          NUM_CORES  = 4,
  parameter int          CORE_BITS  = 2,
  parameter int          DATA_WIDTH = 32,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] REG_MASK   = 32'h03FC_0200
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_CORES-1:0]            write,
  input  logic [NUM_CORES*5-1:0]          write_reg,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] write_data,
  output logic                            to_peripheral_valid,
  input  logic                            to_peripheral_ready,
  output logic [CORE_BITS-1:0]            to_peripheral_core,
  output logic [4:0]                      to_peripheral_reg,
  output logic [DATA_WIDTH-1:0]           to_peripheral_data,
  output logic [NUM_CORES-1:0]            overflow
`ifdef REPORTER_DROP_COUNT_EN
  ,
  output logic [NUM_CORES*16-1:0]         drop_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 5 + DATA_WIDTH;

  // Entry layout: {reg[4:0], data}
  logic [EW-1:0]        mem    [NUM_CORES][FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr [NUM_CORES];
  logic [PW-1:0]        rd_ptr [NUM_CORES];

  logic [NUM_CORES-1:0] qual;
  logic [NUM_CORES-1:0] empty;
  logic [NUM_CORES-1:0] full;
  logic [NUM_CORES-1:0] push;
  logic [NUM_CORES-1:0] pop;
  logic [NUM_CORES-1:0] drop;

  logic [CORE_BITS-1:0] rr_ptr;
  logic [CORE_BITS-1:0] rr_next;
  logic [CORE_BITS-1:0] sel_id;
  logic [EW-1:0]        sel_entry;
  logic                 sel_found;
  logic                 load;

  // Per-core write qualification and FIFO status flags
  always_comb begin
    qual  = '0;
    empty = '0;
    full  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      qual[i]  = write[i] && REG_MASK[write_reg[5*i +: 5]] && (write_reg[5*i +: 5] != 5'd0);
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                 (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
    end
  end

  // Round-robin pick: first pass scans cores >= rr_ptr, second pass wraps to cores below it
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    sel_entry = '0;
    rr_next   = rr_ptr;
    pop       = '0;
    load      = !to_peripheral_valid || to_peripheral_ready;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!sel_found && !empty[i] && ((pass == 0) == (i >= int'(rr_ptr)))) begin
          sel_found = 1'b1;
          sel_id    = CORE_BITS'(i);
          sel_entry = mem[i][rd_ptr[i][AW-1:0]];
          rr_next   = (i == NUM_CORES - 1) ? '0 : CORE_BITS'(i + 1);
        end
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      pop[i] = load && sel_found && (sel_id == CORE_BITS'(i));
    end
  end

  // Push/drop decision: a full FIFO still accepts if it is being popped this cycle
  always_comb begin
    push = '0;
    drop = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      push[i] = qual[i] && (!full[i] || pop[i]);
      drop[i] = qual[i] && full[i] && !pop[i];
    end
  end

  // FIFO storage; contents are don't-care while pointers say empty, so no reset
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i][AW-1:0]] <= {write_reg[5*i +: 5], write_data[DATA_WIDTH*i +: DATA_WIDTH]};
      end
    end
  end

  // FIFO pointers and sticky overflow flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      overflow <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (drop[i]) overflow[i] <= 1'b1;
      end
    end
  end

  // Output register and round-robin pointer; payload only changes on load
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_peripheral_valid <= 1'b0;
      to_peripheral_core  <= '0;
      to_peripheral_reg   <= '0;
      to_peripheral_data  <= '0;
      rr_ptr              <= '0;
    end else if (load) begin
      to_peripheral_valid <= sel_found;
      if (sel_found) begin
        to_peripheral_core <= sel_id;
        to_peripheral_reg  <= sel_entry[EW-1 -: 5];
        to_peripheral_data <= sel_entry[DATA_WIDTH-1:0];
        rr_ptr             <= rr_next;
      end
    end
  end

`ifdef REPORTER_DROP_COUNT_EN
  // Per-core dropped-entry counters, saturating at all ones
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (drop[i] && (drop_count[16*i +: 16] != 16'hFFFF)) begin
          drop_count[16*i +: 16] <= drop_count[16*i +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_core_result_reporter.sv
module tb_core_result_reporter;

  localparam int          NC    = 4;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] MASK  = 32'h03FC_0200;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NC-1:0]   write = '0;
  logic [NC*5-1:0] write_reg = '0;
  logic [NC*DW-1:0] write_data = '0;
  logic            to_peripheral_valid;
  logic            to_peripheral_ready = 1'b0;
  logic [1:0]      to_peripheral_core;
  logic [4:0]      to_peripheral_reg;
  logic [DW-1:0]   to_peripheral_data;
  logic [NC-1:0]   overflow;
`ifdef REPORTER_DROP_COUNT_EN
  logic [NC*16-1:0] drop_count;
`endif

  core_result_reporter dut (
    .clock               (clock),
    .reset               (reset),
    .write               (write),
    .write_reg           (write_reg),
    .write_data          (write_data),
    .to_peripheral_valid (to_peripheral_valid),
    .to_peripheral_ready (to_peripheral_ready),
    .to_peripheral_core  (to_peripheral_core),
    .to_peripheral_reg   (to_peripheral_reg),
    .to_peripheral_data  (to_peripheral_data),
    .overflow            (overflow)
`ifdef REPORTER_DROP_COUNT_EN
    ,
    .drop_count          (drop_count)
`endif
  );

  always #5 clock = ~clock;

  int vectors    = 0;
  int miscompares = 0;

  // Stimulus staging, one slot per core
  logic [4:0]  wreg_a [NC];
  logic [31:0] wdat_a [NC];

  // Reference model: per-core queues of {reg,data}, one output slot, rr pointer
  logic [36:0] mq [NC][$];
  logic        m_valid;
  int          m_core;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  int          m_rr;
  logic [NC-1:0] m_ovf;
  int          m_drop [NC];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      mq[c].delete();
      m_drop[c] = 0;
    end
    m_valid = 1'b0;
    m_core  = 0;
    m_reg   = '0;
    m_data  = '0;
    m_rr    = 0;
    m_ovf   = '0;
  endtask

  // One clock edge of the reporter as described by its rules
  task automatic model_edge();
    int sel;
    logic [36:0] e;
    if (!m_valid || to_peripheral_ready) begin
      sel = -1;
      for (int k = 0; k < NC; k++) begin
        if (sel < 0 && mq[(m_rr + k) % NC].size() > 0) sel = (m_rr + k) % NC;
      end
      if (sel >= 0) begin
        e       = mq[sel].pop_front();
        m_valid = 1'b1;
        m_core  = sel;
        m_reg   = e[36:32];
        m_data  = e[31:0];
        m_rr    = (sel + 1) % NC;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (write[c] && MASK[wreg_a[c]] && wreg_a[c] != 5'd0) begin
        if (mq[c].size() < DEPTH) mq[c].push_back({wreg_a[c], wdat_a[c]});
        else begin
          m_ovf[c] = 1'b1;
          if (m_drop[c] < 16'hFFFF) m_drop[c]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("valid", {63'd0, to_peripheral_valid}, {63'd0, m_valid});
    if (m_valid) begin
      check("core", {62'd0, to_peripheral_core}, 64'(m_core));
      check("reg",  {59'd0, to_peripheral_reg}, {59'd0, m_reg});
      check("data", {32'd0, to_peripheral_data}, {32'd0, m_data});
    end
    check("overflow", {60'd0, overflow}, {60'd0, m_ovf});
`ifdef REPORTER_DROP_COUNT_EN
    for (int c = 0; c < NC; c++) check("drop_count", {48'd0, drop_count[16*c +: 16]}, 64'(m_drop[c]));
`endif
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, compare
  task automatic step(input logic [NC-1:0] w, input logic rdy);
    write               = w;
    write_reg           = {wreg_a[3], wreg_a[2], wreg_a[1], wreg_a[0]};
    write_data          = {wdat_a[3], wdat_a[2], wdat_a[1], wdat_a[0]};
    to_peripheral_ready = rdy;
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    write = '0;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_valid",    {63'd0, to_peripheral_valid}, 64'd0);
    check("rst_overflow", {60'd0, overflow}, 64'd0);
    check("rst_core",     {62'd0, to_peripheral_core}, 64'd0);
    check("rst_reg",      {59'd0, to_peripheral_reg}, 64'd0);
    check("rst_data",     {32'd0, to_peripheral_data}, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [4:0] pick_reg();
    int k;
    if ($urandom_range(0, 2) != 0) begin
      k = $urandom_range(0, 8);
      return (k == 0) ? 5'd9 : 5'(17 + k);
    end
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    for (int c = 0; c < NC; c++) begin
      wreg_a[c] = '0;
      wdat_a[c] = '0;
    end
    #2;
    do_reset();

    // Single masked write from core 0
    wreg_a[0] = 5'd9; wdat_a[0] = 32'd5;
    step(4'b0001, 1'b1);
    check("t1_no_bypass", {63'd0, to_peripheral_valid}, 64'd0);
    step(4'b0000, 1'b1);
    check("t1_valid", {63'd0, to_peripheral_valid}, 64'd1);
    check("t1_core",  {62'd0, to_peripheral_core}, 64'd0);
    check("t1_reg",   {59'd0, to_peripheral_reg}, 64'd9);
    check("t1_data",  {32'd0, to_peripheral_data}, 64'd5);
    step(4'b0000, 1'b1);
    check("t1_empty", {63'd0, to_peripheral_valid}, 64'd0);

    // Unmasked register and x0 from core 1 are ignored
    wreg_a[1] = 5'd5; wdat_a[1] = 32'hAA;
    step(4'b0010, 1'b1);
    wreg_a[1] = 5'd0;
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("t2_valid", {63'd0, to_peripheral_valid}, 64'd0);
    check("t2_ovf",   {60'd0, overflow}, 64'd0);

    // All cores write x18 in one cycle, rr starts at 0
    do_reset();
    for (int c = 0; c < NC; c++) begin
      wreg_a[c] = 5'd18;
      wdat_a[c] = 32'(10 + c);
    end
    step(4'b1111, 1'b1);
    for (int k = 0; k < NC; k++) begin
      step(4'b0000, 1'b1);
      check("t3_core", {62'd0, to_peripheral_core}, 64'(k));
      check("t3_data", {32'd0, to_peripheral_data}, 64'(10 + k));
    end
    step(4'b0000, 1'b1);
    check("t3_done", {63'd0, to_peripheral_valid}, 64'd0);

    // Overflow on core 2 with output stalled
    wreg_a[2] = 5'd20;
    for (int k = 1; k <= 6; k++) begin
      wdat_a[2] = 32'(k);
      step(4'b0100, 1'b0);
    end
    check("t4_hold_data", {32'd0, to_peripheral_data}, 64'd1);
    check("t4_ovf",       {60'd0, overflow}, 64'h4);
`ifdef REPORTER_DROP_COUNT_EN
    check("t4_drop2", {48'd0, drop_count[47:32]}, 64'd1);
`endif
    for (int k = 2; k <= 5; k++) begin
      step(4'b0000, 1'b1);
      check("t4_beat", {32'd0, to_peripheral_data}, 64'(k));
    end
    step(4'b0000, 1'b1);
    check("t4_done", {63'd0, to_peripheral_valid}, 64'd0);

    // Randomized traffic with random stalls and one asynchronous reset mid-stream
    for (int n = 0; n < 1500; n++) begin
      logic [NC-1:0] w;
      for (int c = 0; c < NC; c++) begin
        wreg_a[c] = pick_reg();
        wdat_a[c] = $urandom;
      end
      w = 4'($urandom);
      step(w, (n < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      if (n == 700) begin
        write = '0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_valid", {63'd0, to_peripheral_valid}, 64'd0);
        check("async_ovf",   {60'd0, overflow}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
      end
    end

    // Drain with ready held high
    for (int n = 0; n < 24; n++) step(4'b0000, 1'b1);
    check("final_empty", {63'd0, to_peripheral_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
